bomb_placer: RTL and testbench

//  Board writer for the minesweeper datapath. On start, clears the board cell memory, then places
//  a requested number of bombs at pseudo-random distinct cells, excluding the player's safe cell.
//  It fills the same 1-bit-per-cell board memory that the cell-scan/count FSM later reads.
//  It runs once per game, before the scan FSM is released.

---
 rtl/bomb_placer.sv | 155 +++++++++++++++
 tb/tb_bomb_placer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bomb_placer.sv
`default_nettype none
// ============================================================================
//  Module      : bomb_placer
//  Description : Minesweeper board writer. On start it clears the 1-bit-per-
//                cell board memory, then places the requested number of bombs
//                at pseudo-random, distinct cells, never on the safe cell.
//  Ports       : clk, rst (async, active-low)
//                start, num_bombs, safe_addr      - placement request
//                mem_addr, mem_we, mem_wdata      - board memory write/read port
//                mem_rdata                        - cell data, one cycle after addr
//                busy, done, bombs_placed         - status
//  Revision    : 1.0 - initial release
// ============================================================================
module bomb_placer #(
    parameter int          ROWS   = 8,
    parameter int          COLS   = 8,
    parameter int          ADDR_W = 6,
    parameter logic [15:0] SEED   = 16'hACE1   // must be nonzero or the LFSR locks up
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   num_bombs,
    input  logic [ADDR_W-1:0] safe_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_wdata,
    input  logic              mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   bombs_placed
);

    localparam int                c_CELLS      = ROWS * COLS;
    localparam logic [ADDR_W:0]   c_CELLS_W    = (ADDR_W+1)'(c_CELLS);
    localparam logic [ADDR_W:0]   c_MAX_TARGET = (ADDR_W+1)'(c_CELLS - 1);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR  = ADDR_W'(c_CELLS - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_CLEAR  = 3'd1;
    localparam logic [2:0] c_GEN    = 3'd2;
    localparam logic [2:0] c_READ   = 3'd3;
    localparam logic [2:0] c_CHECK  = 3'd4;
    localparam logic [2:0] c_WRITE  = 3'd5;
    localparam logic [2:0] c_FINISH = 3'd6;

    logic [2:0]        r_state;
    logic [15:0]       r_lfsr;
    logic [ADDR_W-1:0] r_clr_addr;
    logic [ADDR_W-1:0] r_cand;
    logic [ADDR_W-1:0] r_safe;
    logic [ADDR_W:0]   r_target;
    logic [ADDR_W:0]   r_count;

    logic              w_feedback;
    logic [ADDR_W-1:0] w_cand;
    logic              w_cand_ok;
    logic [ADDR_W:0]   w_target;
    logic [ADDR_W:0]   w_count_nxt;

    // Fibonacci LFSR, taps 16,14,13,11 (bit indices 15,13,12,10).
    assign w_feedback  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_cand      = r_lfsr[ADDR_W-1:0];
    // A safe_addr outside the board never matches an in-range candidate,
    // so it naturally excludes nothing.
    assign w_cand_ok   = ({1'b0, w_cand} < c_CELLS_W) && (w_cand != r_safe);
    // Capping at CELLS-1 guarantees at least one free non-safe cell remains,
    // so the unbounded retry loop always terminates.
    assign w_target    = (num_bombs > c_MAX_TARGET) ? c_MAX_TARGET : num_bombs;
    assign w_count_nxt = r_count + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_IDLE;
            r_lfsr     <= SEED;
            r_clr_addr <= '0;
            r_cand     <= '0;
            r_safe     <= '0;
            r_target   <= '0;
            r_count    <= '0;
        end else begin
            // Free-running: the placement pattern depends on when start arrives.
            r_lfsr <= {r_lfsr[14:0], w_feedback};
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state    <= c_CLEAR;
                        r_clr_addr <= '0;
                        r_count    <= '0;
                        r_target   <= w_target;
                        r_safe     <= safe_addr;
                    end
                end
                c_CLEAR: begin
                    r_clr_addr <= r_clr_addr + 1'b1;
                    if (r_clr_addr == c_LAST_ADDR) begin
                        r_state <= (r_target == '0) ? c_FINISH : c_GEN;
                    end
                end
                c_GEN: begin
                    if (w_cand_ok) begin
                        r_cand  <= w_cand;
                        r_state <= c_READ;
                    end
                end
                c_READ: begin
                    r_state <= c_CHECK;
                end
                c_CHECK: begin
                    // Cell already holds a bomb: draw another candidate.
                    r_state <= mem_rdata ? c_GEN : c_WRITE;
                end
                c_WRITE: begin
                    r_count <= w_count_nxt;
                    r_state <= (w_count_nxt == r_target) ? c_FINISH : c_GEN;
                end
                c_FINISH: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = 1'b0;
        case (r_state)
            c_CLEAR: begin
                mem_addr = r_clr_addr;
                mem_we   = 1'b1;
            end
            c_READ: begin
                mem_addr = r_cand;
            end
            c_WRITE: begin
                mem_addr  = r_cand;
                mem_we    = 1'b1;
                mem_wdata = 1'b1;
            end
            default: begin
                mem_addr = '0;
            end
        endcase
    end

    assign busy         = (r_state != c_IDLE) && (r_state != c_FINISH);
    assign done         = (r_state == c_FINISH);
    assign bombs_placed = r_count;

endmodule
`default_nettype wire

// File: tb/tb_bomb_placer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bomb_placer
//  Description : Self-checking bench for bomb_placer. A reference model
//                expands each request into the expected per-cycle output
//                sequence from the LFSR and the placement rules; one process
//                compares the DUT against it every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bomb_placer;

    localparam int          CELLS = 64;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [6:0] num_bombs = '0;
    logic [5:0] safe_addr = '0;
    logic [5:0] mem_addr;
    logic       mem_we;
    logic       mem_wdata;
    logic       mem_rdata;
    logic       busy;
    logic       done;
    logic [6:0] bombs_placed;

    always #5 clk = ~clk;

    bomb_placer #(.ROWS(8), .COLS(8), .ADDR_W(6), .SEED(SEED)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_bombs    (num_bombs),
        .safe_addr    (safe_addr),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .busy         (busy),
        .done         (done),
        .bombs_placed (bombs_placed)
    );

    // Board memory with registered read; pm_* lets a cell appear pre-marked.
    logic       mem [0:CELLS-1];
    logic       pm_en = 1'b0;
    logic [5:0] pm_addr = '0;
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr] | (pm_en && (mem_addr == pm_addr));
    end

    typedef struct {
        logic [5:0] addr;
        bit         chk_addr;
        logic       we;
        logic       wd;
        logic       busy;
        logic       done;
        logic [6:0] cnt;
    } exp_t;

    exp_t        q[$];
    logic [15:0] m_lfsr = SEED;
    logic [6:0]  exp_cnt = '0;
    bit          bd [0:CELLS-1];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          clr_wr = 0;
    int          bomb_wr = 0;
    int          done_cnt = 0;
    logic [5:0]  safe_lat = '0;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic exp_t mk(input int a, input bit ca, input bit we, input bit wd,
                                input bit bz, input bit dn, input int cnt);
        exp_t e;
        e.addr = 6'(a); e.chk_addr = ca; e.we = we; e.wd = wd;
        e.busy = bz; e.done = dn; e.cnt = 7'(cnt);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expand one request into the expected output of every cycle from the
    // cycle after start through the done pulse.
    task automatic build(input int nb, input int sa, input bit pm);
        int          target;
        int          cnt;
        int          guard;
        bit          first;
        logic [15:0] l;
        int          cand;
        target = (nb > CELLS - 1) ? CELLS - 1 : nb;
        cnt    = 0;
        guard  = 0;
        first  = 1'b1;
        pm_en  = 1'b0;
        l      = lfsr_next(m_lfsr);
        for (int a = 0; a < CELLS; a++) begin
            q.push_back(mk(a, 1, 1, 0, 1, 0, 0));
            bd[a] = 1'b0;
            l = lfsr_next(l);
        end
        while (cnt < target && guard < 30000) begin
            guard++;
            cand = int'(l[5:0]);
            q.push_back(mk(0, 0, 0, 0, 1, 0, cnt));
            l = lfsr_next(l);
            if (cand >= CELLS || cand == sa) continue;
            if (pm && first) begin
                pm_addr = 6'(cand);
                pm_en   = 1'b1;
                bd[cand] = 1'b1;
                first   = 1'b0;
            end
            q.push_back(mk(cand, 1, 0, 0, 1, 0, cnt));
            l = lfsr_next(l);
            q.push_back(mk(0, 0, 0, 0, 1, 0, cnt));
            l = lfsr_next(l);
            if (bd[cand]) continue;
            q.push_back(mk(cand, 1, 1, 1, 1, 0, cnt));
            bd[cand] = 1'b1;
            cnt++;
            l = lfsr_next(l);
        end
        q.push_back(mk(0, 0, 0, 0, 0, 1, target));
    endtask

    // Single compare process: one sample per cycle, just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                m_lfsr  = SEED;
                q.delete();
                exp_cnt = '0;
            end else begin
                m_lfsr = lfsr_next(m_lfsr);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    exp_cnt = e.cnt;
                    check("mem_we", mem_we, e.we);
                    check("mem_wdata", mem_wdata, e.wd);
                    check("busy", busy, e.busy);
                    check("done", done, e.done);
                    check("bombs_placed", bombs_placed, e.cnt);
                    if (e.chk_addr) check("mem_addr", mem_addr, e.addr);
                end else begin
                    check("idle_we", mem_we, 0);
                    check("idle_busy", busy, 0);
                    check("idle_done", done, 0);
                    check("idle_count", bombs_placed, exp_cnt);
                end
                if (mem_we && !mem_wdata) clr_wr++;
                if (mem_we && mem_wdata) begin
                    bomb_wr++;
                    check("bomb_not_on_safe", (mem_addr == safe_lat), 0);
                end
                if (done) done_cnt++;
            end
        end
    end

    task automatic do_start(input int nb, input int sa, input bit pm);
        @(negedge clk);
        start     = 1'b1;
        num_bombs = 7'(nb);
        safe_addr = 6'(sa);
        safe_lat  = 6'(sa);
        clr_wr    = 0;
        bomb_wr   = 0;
        done_cnt  = 0;
        build(nb, sa, pm);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("run_timeout_left", q.size(), 0);
        @(negedge clk);
    endtask

    task automatic final_checks(input int target, input int sa, input bit pm);
        int bad;
        int ones;
        bad  = 0;
        ones = 0;
        for (int i = 0; i < CELLS; i++) begin
            if (mem[i] !== (bd[i] && !(pm && i == int'(pm_addr)))) bad++;
            if (mem[i] === 1'b1) ones++;
        end
        check("clear_writes", clr_wr, 64);
        check("bomb_writes", bomb_wr, target);
        check("done_pulses", done_cnt, 1);
        check("final_count", bombs_placed, target);
        check("board_vs_model", bad, 0);
        check("board_bombs", ones, target);
        check("safe_cell_empty", mem[sa], 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_count"}, bombs_placed, 0);
    endtask

    initial begin
        int n;
        int nb;
        int sa;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 10 bombs, safe cell 0
        do_start(10, 0, 0);
        wait_idle(20000);
        final_checks(10, 0, 0);

        // zero bombs: clear only
        do_start(0, 9, 0);
        wait_idle(20000);
        final_checks(0, 9, 0);

        // oversize request fills every cell but the safe one
        do_start(127, 5, 0);
        wait_idle(20000);
        final_checks(63, 5, 0);

        // pre-marked candidate must be skipped, not rewritten
        do_start(8, 17, 1);
        wait_idle(20000);
        final_checks(8, 17, 1);
        pm_en = 1'b0;

        // second start while busy is ignored
        do_start(12, 30, 0);
        repeat (100) @(negedge clk);
        start     = 1'b1;
        num_bombs = 7'd50;
        safe_addr = 6'd3;
        @(negedge clk);
        start = 1'b0;
        wait_idle(20000);
        final_checks(12, 30, 0);

        // reset in the middle of placement, then a fresh run
        do_start(20, 7, 0);
        n = 0;
        while (bomb_wr < 2 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("reached_placement", (bomb_wr >= 2), 1);
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        do_start(3, 40, 0);
        wait_idle(20000);
        final_checks(3, 40, 0);

        // randomized requests at random start phases
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(0, 20)) @(negedge clk);
            nb = int'($urandom_range(0, 127));
            sa = int'($urandom_range(0, 63));
            do_start(nb, sa, 0);
            wait_idle(20000);
            final_checks((nb > 63) ? 63 : nb, sa, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
